// File: rtl/adres_pe_ctx.sv
// Multi-context ADRES processing element: serial config chain, per-cycle
// context counter, operand muxes, FU, local register file, registered output.
module adres_pe_ctx #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned NUM_IN   = 5,
  parameter int unsigned CONTEXTS = 2,
  parameter int unsigned RF_DEPTH = 4
) (
  input  logic                    Config_Clock,
  input  logic                    Config_Reset,
  input  logic                    ConfigEnable,
  input  logic                    ConfigIn,
  output logic                    ConfigOut,
  input  logic                    run,
  input  logic [NUM_IN*WIDTH-1:0] in,
  output logic [WIDTH-1:0]        out
);

  localparam int unsigned CTXW = (CONTEXTS > 1) ? $clog2(CONTEXTS) : 1;
  localparam int unsigned AW   = $clog2(RF_DEPTH);
  localparam int unsigned SELW = $clog2(NUM_IN + 3);
  localparam int unsigned SHW  = $clog2(WIDTH);
  localparam int unsigned CW   = 4 + 2*SELW + 2*AW + 2 + WIDTH;
  localparam int unsigned L    = CTXW + CONTEXTS*CW;
  localparam logic [CTXW-1:0] CTX_LAST = CTXW'(CONTEXTS - 1);

  // One context word; first member is the MSB of the chain slice.
  typedef struct packed {
    logic [WIDTH-1:0] cst;
    logic             out_we;
    logic             rf_we;
    logic [AW-1:0]    rf_wa;
    logic [AW-1:0]    rf_ra;
    logic [SELW-1:0]  selb;
    logic [SELW-1:0]  sela;
    logic [3:0]       func;
  } ctx_word_t;

  logic [L-1:0]     chain;
  logic [CTXW-1:0]  ctx;
  logic [CTXW-1:0]  ii;
  logic [CTXW-1:0]  ii_eff;
  logic [WIDTH-1:0] rf [RF_DEPTH];
  ctx_word_t        act;
  logic [WIDTH-1:0] rf_val;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] result;
  logic             exec;

  // Operand source decode: neighbour inputs, constant, RF, or own output.
  function automatic logic [WIDTH-1:0] pick(
    input logic [SELW-1:0]         sel,
    input logic [NUM_IN*WIDTH-1:0] bus,
    input logic [WIDTH-1:0]        cst,
    input logic [WIDTH-1:0]        rfv,
    input logic [WIDTH-1:0]        acc
  );
    logic [WIDTH-1:0] v;
    v = '0;
    for (int unsigned k = 0; k < NUM_IN; k++) begin
      if (sel == SELW'(k)) v = bus[k*WIDTH +: WIDTH];
    end
    if (sel == SELW'(NUM_IN))     v = cst;
    if (sel == SELW'(NUM_IN + 1)) v = rfv;
    if (sel == SELW'(NUM_IN + 2)) v = acc;
    return v;
  endfunction

  assign ConfigOut = chain[0];
  assign ii        = chain[CTXW-1:0];
  assign ii_eff    = (ii > CTX_LAST) ? CTX_LAST : ii;
  assign exec      = run & ~ConfigEnable;

  // Select the active context word from the chain.
  always_comb begin
    act = '0;
    for (int unsigned c = 0; c < CONTEXTS; c++) begin
      if (ctx == CTXW'(c)) act = chain[CTXW + c*CW +: CW];
    end
  end

  // Operand muxes; RF read returns the pre-write value this cycle.
  always_comb begin
    rf_val = rf[act.rf_ra];
    opa    = pick(act.sela, in, act.cst, rf_val, out);
    opb    = pick(act.selb, in, act.cst, rf_val, out);
  end

  // Functional unit; all arithmetic wraps at WIDTH bits.
  always_comb begin
    shamt  = opb[SHW-1:0];
    result = '0;
    case (act.func)
      4'd0:    result = opa + opb;
      4'd1:    result = opa - opb;
      4'd2:    result = opa * opb;
      4'd3:    result = opa & opb;
      4'd4:    result = opa | opb;
      4'd5:    result = opa ^ opb;
      4'd6:    result = opa << shamt;
      4'd7:    result = $signed(opa) >>> shamt;
      4'd8:    result = opa >> shamt;
      4'd9:    result = opa;
      4'd10:   result = {{(WIDTH-1){1'b0}}, ($signed(opa) < $signed(opb))};
      default: result = '0;
    endcase
  end

  // Config chain: shift toward bit 0 while enabled.
  always_ff @(posedge Config_Clock) begin
    if (!Config_Reset) begin
      chain <= '0;
    end else if (ConfigEnable) begin
      chain <= {ConfigIn, chain[L-1:1]};
    end
  end

  // Context counter: wraps after ii_eff, zeroed during configuration.
  always_ff @(posedge Config_Clock) begin
    if (!Config_Reset) begin
      ctx <= '0;
    end else if (ConfigEnable) begin
      ctx <= '0;
    end else if (run) begin
      ctx <= (ctx >= ii_eff) ? '0 : ctx + CTXW'(1);
    end
  end

  // Output register and register file writes.
  always_ff @(posedge Config_Clock) begin
    if (!Config_Reset) begin
      out <= '0;
      for (int unsigned i = 0; i < RF_DEPTH; i++) rf[i] <= '0;
    end else if (exec) begin
      if (act.out_we) out <= result;
      if (act.rf_we)  rf[act.rf_wa] <= result;
    end
  end

endmodule
